// File: rtl/ftdi_fifo_bridge.sv
`timescale 1ns/1ps
// FT245-style async FIFO bridge: buffered TX/RX byte streams to FTDI pins,
// per-phase RD#/WR#/SIWU# timing, fair RX/TX arbitration, idle SIWU# flush.
// Ports: clk_i/rst_ni; FTDI pins ftdi_*; TX stream tx_*; RX stream rx_*;
// tx_level_o/rx_level_o report buffer occupancy (0..DEPTH).
module ftdi_fifo_bridge #(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int RD_PULSE  = 4,
  parameter int WR_SETUP  = 2,
  parameter int WR_PULSE  = 3,
  parameter int RECOVER   = 4,
  parameter int SIWU_IDLE = 0,
  parameter int CNT_W     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ftdi_rxf_ni,
  input  logic                      ftdi_txe_ni,
  input  logic [7:0]                ftdi_d_i,
  output logic [7:0]                ftdi_d_o,
  output logic                      ftdi_d_oe_o,
  output logic                      ftdi_rd_no,
  output logic                      ftdi_wr_no,
  output logic                      ftdi_siwu_no,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [7:0]                rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic [$clog2(TX_DEPTH):0] tx_level_o,
  output logic [$clog2(RX_DEPTH):0] rx_level_o
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RX   = 3'd1;
  localparam logic [2:0] S_TXS  = 3'd2;
  localparam logic [2:0] S_TXP  = 3'd3;
  localparam logic [2:0] S_TXH  = 3'd4;
  localparam logic [2:0] S_REC  = 3'd5;
  localparam logic [2:0] S_SIWU = 3'd6;

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_RD   = CNT_W'(RD_PULSE - 1);
  localparam logic [CNT_W-1:0] C_WS   = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] C_WP   = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] C_REC  = CNT_W'(RECOVER - 1);
  localparam logic [CNT_W-1:0] C_SIWU = CNT_W'(SIWU_IDLE);
  localparam logic [TAW:0]     TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]     RX_FULL = (RAW+1)'(RX_DEPTH);
  localparam logic             SIWU_EN = (SIWU_IDLE != 0);

  logic [1:0]       r_rxf_sync, r_txe_sync;
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [TAW-1:0]   r_tx_wp, r_tx_rp;
  logic [RAW-1:0]   r_rx_wp, r_rx_rp;
  logic [TAW:0]     r_tx_lvl;
  logic [RAW:0]     r_rx_lvl;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt, r_idle;
  logic             r_rd_n, r_wr_n, r_siwu_n, r_oe, r_last_tx, r_sent;
  logic [7:0]       r_dout;

  logic w_rxf, w_txe, w_idle, w_rx_ok, w_tx_ok;
  logic w_grant_rx, w_grant_tx, w_siwu_go, w_idle_cnt;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

  assign w_rxf = r_rxf_sync[1];
  assign w_txe = r_txe_sync[1];
  assign w_idle = (r_state == S_IDLE);
  assign w_rx_ok = ~w_rxf & (r_rx_lvl < RX_FULL);
  assign w_tx_ok = ~w_txe & (r_tx_lvl != '0);
  // On a tie the side that did not win last time gets the bus.
  assign w_grant_rx = w_idle & w_rx_ok & (~w_tx_ok | r_last_tx);
  assign w_grant_tx = w_idle & w_tx_ok & (~w_rx_ok | ~r_last_tx);
  assign w_siwu_go = SIWU_EN & w_idle & ~w_rx_ok & ~w_tx_ok & r_sent
                   & (r_tx_lvl == '0) & (r_idle == C_SIWU) & ~w_tx_push;
  assign w_idle_cnt = w_idle & r_sent & (r_tx_lvl == '0) & (r_idle != C_SIWU);

  assign tx_ready_o = (r_tx_lvl != TX_FULL);
  assign rx_valid_o = (r_rx_lvl != '0);
  assign rx_data_o  = r_rx_mem[r_rx_rp];
  assign tx_level_o = r_tx_lvl;
  assign rx_level_o = r_rx_lvl;

  assign w_tx_push = tx_valid_i & tx_ready_o;
  assign w_tx_pop  = w_grant_tx;
  assign w_rx_push = (r_state == S_RX) & (r_cnt == C_RD);
  assign w_rx_pop  = rx_valid_o & rx_ready_i;

  assign ftdi_rd_no   = r_rd_n;
  assign ftdi_wr_no   = r_wr_n;
  assign ftdi_siwu_no = r_siwu_n;
  assign ftdi_d_oe_o  = r_oe;
  assign ftdi_d_o     = r_dout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rxf_sync <= 2'b11;
      r_txe_sync <= 2'b11;
    end else begin
      r_rxf_sync <= {r_rxf_sync[0], ftdi_rxf_ni};
      r_txe_sync <= {r_txe_sync[0], ftdi_txe_ni};
    end
  end

  // Storage arrays carry no reset; pointers and levels define validity.
  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data_i;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= ftdi_d_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_lvl <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_lvl <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TAW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TAW'(1);
      if (w_rx_push) r_rx_wp <= r_rx_wp + RAW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RAW'(1);
      unique case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_lvl <= r_tx_lvl + (TAW+1)'(1);
        2'b01:   r_tx_lvl <= r_tx_lvl - (TAW+1)'(1);
        default: r_tx_lvl <= r_tx_lvl;
      endcase
      unique case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_lvl <= r_rx_lvl + (RAW+1)'(1);
        2'b01:   r_rx_lvl <= r_rx_lvl - (RAW+1)'(1);
        default: r_rx_lvl <= r_rx_lvl;
      endcase
    end
  end

  // Flush countdown: restarts on any write strobe or new TX byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idle <= '0;
      r_sent <= 1'b0;
    end else begin
      if (w_tx_push || r_state == S_TXP) r_idle <= '0;
      else if (w_idle_cnt)               r_idle <= r_idle + C_ONE;
      if (w_grant_tx) r_sent <= 1'b1;
      else if (r_state == S_SIWU && r_cnt == C_WP) r_sent <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_siwu_n  <= 1'b1;
      r_oe      <= 1'b0;
      r_dout    <= 8'h00;
      r_last_tx <= 1'b1;
    end else begin
      r_cnt <= r_cnt + C_ONE;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_rx) begin
            r_state   <= S_RX;
            r_rd_n    <= 1'b0;
            r_last_tx <= 1'b0;
          end else if (w_grant_tx) begin
            r_state   <= S_TXS;
            r_oe      <= 1'b1;
            r_dout    <= r_tx_mem[r_tx_rp];
            r_last_tx <= 1'b1;
          end else if (w_siwu_go) begin
            r_state  <= S_SIWU;
            r_siwu_n <= 1'b0;
          end
        end
        S_RX: if (r_cnt == C_RD) begin
          r_rd_n  <= 1'b1;
          r_state <= S_REC;
          r_cnt   <= '0;
        end
        S_TXS: if (r_cnt == C_WS) begin
          r_wr_n  <= 1'b0;
          r_state <= S_TXP;
          r_cnt   <= '0;
        end
        S_TXP: if (r_cnt == C_WP) begin
          r_wr_n  <= 1'b1;
          r_state <= S_TXH;
          r_cnt   <= '0;
        end
        S_TXH: begin
          r_oe    <= 1'b0;
          r_state <= S_REC;
          r_cnt   <= '0;
        end
        S_REC: if (r_cnt == C_REC) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        S_SIWU: if (r_cnt == C_WP) begin
          r_siwu_n <= 1'b1;
          r_state  <= S_REC;
          r_cnt    <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
`timescale 1ns/1ps
// Testbench for ftdi_fifo_bridge: FTDI pin model, pin-activity monitor and
// byte scoreboards for TX and RX; one task per scenario.
module tb_ftdi_fifo_bridge;
  localparam int RXD = 4;
  localparam int SIW = 10;
  localparam int RDP = 4;
  localparam int WS  = 2;
  localparam int WP  = 3;
  localparam int REC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rxf_n, txe_n;
  logic [7:0] d_i, d_o, tx_data, rx_data;
  logic       oe, rd_n, wr_n, siwu_n;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [4:0] tx_level;
  logic [2:0] rx_level;

  ftdi_fifo_bridge #(.RX_DEPTH(RXD), .SIWU_IDLE(SIW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ftdi_rxf_ni(rxf_n), .ftdi_txe_ni(txe_n),
    .ftdi_d_i(d_i), .ftdi_d_o(d_o), .ftdi_d_oe_o(oe),
    .ftdi_rd_no(rd_n), .ftdi_wr_no(wr_n), .ftdi_siwu_no(siwu_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_level_o(tx_level), .rx_level_o(rx_level)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_exp[$], rx_exp[$], tx_obs[$], seq[$];
  int rd_w[$], wr_w[$], setup_w[$], hold_w[$], siwu_w[$], rd_gap[$];
  int oe_bad = 0, cyc = 0, t_oe_fall = 0, t_siwu_fall = 0;

  // FTDI side: a fresh byte is presented on every RD# fall.
  logic [7:0] src = 8'h3C;
  logic [7:0] cur = 8'h00;
  assign d_i = cur;

  logic p_rd = 1'b1, p_wr = 1'b1, p_si = 1'b1, in_hold = 1'b0;
  int rd_len = 0, wr_len = 0, si_len = 0, oe_len = 0, hold_len = 0, gap_len = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rd_n) begin
      if (p_rd) begin
        cur = src;
        src = src + 8'h11;
        rx_exp.push_back(cur);
        seq.push_back("R");
        rd_gap.push_back(gap_len);
        rd_len = 0;
      end
      rd_len++;
    end else begin
      if (!p_rd) begin
        rd_w.push_back(rd_len);
        gap_len = 0;
      end
      gap_len++;
    end
    if (!wr_n) begin
      if (p_wr) begin
        seq.push_back("T");
        tx_obs.push_back(d_o);
        setup_w.push_back(oe_len);
        wr_len = 0;
      end
      wr_len++;
      if (!oe) oe_bad++;
    end else if (!p_wr) begin
      wr_w.push_back(wr_len);
      in_hold = 1'b1;
      hold_len = 0;
    end
    if (in_hold) begin
      if (oe) hold_len++;
      else begin
        hold_w.push_back(hold_len);
        in_hold = 1'b0;
        t_oe_fall = cyc;
      end
    end
    if (oe) oe_len++;
    else oe_len = 0;
    if (!siwu_n) begin
      if (p_si) begin
        seq.push_back("S");
        t_siwu_fall = cyc;
        si_len = 0;
      end
      si_len++;
    end else if (!p_si) siwu_w.push_back(si_len);
    p_rd = rd_n;
    p_wr = wr_n;
    p_si = siwu_n;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    tx_exp.delete(); rx_exp.delete(); tx_obs.delete(); seq.delete();
    rd_w.delete(); wr_w.delete(); setup_w.delete(); hold_w.delete();
    siwu_w.delete(); rd_gap.delete();
    oe_bad = 0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    tx_exp.push_back(b);
    tick(1);
    tx_valid = 1'b0;
  endtask

  function automatic int count_seq(input logic [7:0] c);
    int k = 0;
    foreach (seq[i]) if (seq[i] == c) k++;
    return k;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rxf_n = 1'b1; txe_n = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    tick(3);
    checks++;
    if ({rd_n, wr_n, siwu_n, oe} !== 4'b1110) begin
      failures++; $display("FAIL reset_pins got=%b exp=1110", {rd_n, wr_n, siwu_n, oe});
    end
    checks++;
    if (d_o !== 8'h00) begin failures++; $display("FAIL reset_d_o got=%h exp=00", d_o); end
    checks++;
    if ({tx_ready, rx_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_ready_valid got=%b exp=10", {tx_ready, rx_valid});
    end
    checks++;
    if (tx_level !== 5'd0 || rx_level !== 3'd0) begin
      failures++; $display("FAIL reset_levels got=%0d/%0d exp=0/0", tx_level, rx_level);
    end
    rst_n = 1'b1;
    tick(2);
    clear_logs();
  endtask

  task automatic test_single_tx();
    logic [7:0] exp, got;
    int n;
    txe_n = 1'b0;
    tick(3);
    push_tx(8'hA5);
    checks++;
    if (tx_level !== 5'd1) begin failures++; $display("FAIL tx_level_push got=%0d exp=1", tx_level); end
    n = 0;
    while (wr_n !== 1'b0 && n < 50) begin tick(1); n++; end
    checks++;
    if (wr_n !== 1'b0) begin failures++; $display("FAIL tx_wr_timeout got=%b exp=0", wr_n); end
    tick(12);
    exp = tx_exp.pop_front();
    got = (tx_obs.size() != 0) ? tx_obs.pop_front() : 8'h00;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL tx_byte got=%h exp=%h", got, exp); end
    checks++;
    if (setup_w.size() != 1 || setup_w[0] != WS) begin
      failures++; $display("FAIL tx_setup got=%0d exp=%0d", setup_w.size() ? setup_w[0] : -1, WS);
    end
    checks++;
    if (wr_w.size() != 1 || wr_w[0] != WP) begin
      failures++; $display("FAIL tx_wr_width got=%0d exp=%0d", wr_w.size() ? wr_w[0] : -1, WP);
    end
    checks++;
    if (hold_w.size() != 1 || hold_w[0] != 1 || oe_bad != 0) begin
      failures++; $display("FAIL tx_hold_oe got=%0d/%0d exp=1/0", hold_w.size() ? hold_w[0] : -1, oe_bad);
    end
    checks++;
    if (tx_level !== 5'd0) begin failures++; $display("FAIL tx_level_drain got=%0d exp=0", tx_level); end
  endtask

  task automatic test_siwu();
    logic [7:0] exp, got;
    int n, n0;
    n = 0;
    while (siwu_w.size() == 0 && n < 80) begin tick(1); n++; end
    checks++;
    if (siwu_w.size() != 1 || siwu_w[0] != WP) begin
      failures++; $display("FAIL siwu_width got=%0d exp=%0d", siwu_w.size() ? siwu_w[0] : -1, WP);
    end
    n = t_siwu_fall - t_oe_fall;
    checks++;
    if (n < SIW + REC || n > SIW + REC + 2) begin
      failures++; $display("FAIL siwu_delay got=%0d exp=%0d..%0d", n, SIW + REC, SIW + REC + 2);
    end
    tick(40);
    checks++;
    if (siwu_w.size() != 1) begin failures++; $display("FAIL siwu_repeat got=%0d exp=1", siwu_w.size()); end
    n0 = siwu_w.size();
    push_tx(8'h5A);
    n = 0;
    while (wr_n !== 1'b0 && n < 50) begin tick(1); n++; end
    txe_n = 1'b1;
    tick(11);
    push_tx(8'h77);
    tick(40);
    checks++;
    if (siwu_w.size() != n0 || tx_level !== 5'd1) begin
      failures++; $display("FAIL siwu_abandon got=%0d/%0d exp=%0d/1", siwu_w.size(), tx_level, n0);
    end
    txe_n = 1'b0;
    tick(45);
    for (int i = 0; i < 2; i++) begin
      exp = tx_exp.size() ? tx_exp.pop_front() : 8'h00;
      got = tx_obs.size() ? tx_obs.pop_front() : 8'hFF;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL siwu_tx[%0d] got=%h exp=%h", i, got, exp); end
    end
    checks++;
    if (siwu_w.size() != n0 + 1) begin
      failures++; $display("FAIL siwu_after_send got=%0d exp=%0d", siwu_w.size(), n0 + 1);
    end
    txe_n = 1'b1;
    tick(3);
    clear_logs();
  endtask

  task automatic test_single_rx();
    logic [7:0] exp;
    int n;
    rx_ready = 1'b0;
    rxf_n = 1'b0;
    n = 0;
    while (rd_n !== 1'b0 && n < 30) begin tick(1); n++; end
    rxf_n = 1'b1;
    tick(14);
    exp = rx_exp.size() ? rx_exp[0] : 8'h00;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp || exp !== 8'h3C) begin
      failures++; $display("FAIL rx_single got=%h/v%b exp=%h", rx_data, rx_valid, exp);
    end
    checks++;
    if (rx_level !== 3'd1 || count_seq("R") != 1) begin
      failures++; $display("FAIL rx_single_count got=%0d/%0d exp=1/1", rx_level, count_seq("R"));
    end
    checks++;
    if (rd_w.size() != 1 || rd_w[0] != RDP) begin
      failures++; $display("FAIL rx_rd_width got=%0d exp=%0d", rd_w.size() ? rd_w[0] : -1, RDP);
    end
    exp = rx_exp.pop_front();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    checks++;
    if (rx_level !== 3'd0) begin failures++; $display("FAIL rx_pop_level got=%0d exp=0", rx_level); end
    clear_logs();
  endtask

  task automatic test_rx_full();
    logic [7:0] exp;
    rx_ready = 1'b0;
    rxf_n = 1'b0;
    tick(80);
    checks++;
    if (count_seq("R") != RXD || rx_level !== 3'(RXD) || rd_n !== 1'b1) begin
      failures++; $display("FAIL rx_full got=%0d/%0d/%b exp=%0d/%0d/1", count_seq("R"), rx_level, rd_n, RXD, RXD);
    end
    for (int i = 1; i < RXD; i++) begin
      checks++;
      if (rd_gap.size() <= i || rd_gap[i] != REC + 1) begin
        failures++; $display("FAIL rx_gap[%0d] got=%0d exp=%0d", i, rd_gap.size() > i ? rd_gap[i] : -1, REC + 1);
      end
    end
    exp = rx_exp.size() ? rx_exp.pop_front() : 8'h00;
    checks++;
    if (rx_data !== exp) begin failures++; $display("FAIL rx_full_head got=%h exp=%h", rx_data, exp); end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(40);
    checks++;
    if (count_seq("R") != RXD + 1 || rx_level !== 3'(RXD)) begin
      failures++; $display("FAIL rx_refill got=%0d/%0d exp=%0d/%0d", count_seq("R"), rx_level, RXD + 1, RXD);
    end
    rxf_n = 1'b1;
    tick(5);
    for (int i = 0; i < RXD; i++) begin
      exp = rx_exp.size() ? rx_exp.pop_front() : 8'h00;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        failures++; $display("FAIL rx_drain[%0d] got=%h/v%b exp=%h", i, rx_data, rx_valid, exp);
      end
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end
    checks++;
    if (rx_level !== 3'd0 || rx_exp.size() != 0) begin
      failures++; $display("FAIL rx_drained got=%0d/%0d exp=0/0", rx_level, rx_exp.size());
    end
    clear_logs();
  endtask

  task automatic test_fairness();
    logic [7:0] exp, got, want;
    rst_n = 1'b0;
    rxf_n = 1'b1; txe_n = 1'b1; rx_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_logs();
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44);
    rxf_n = 1'b0;
    txe_n = 1'b0;
    tick(120);
    checks++;
    if (seq.size() < 8) begin failures++; $display("FAIL fair_count got=%0d exp>=8", seq.size()); end
    for (int i = 0; i < 8; i++) begin
      want = (i % 2 == 0) ? "R" : "T";
      got = (seq.size() > i) ? seq[i] : "-";
      checks++;
      if (got !== want) begin failures++; $display("FAIL fair_order[%0d] got=%c exp=%c", i, got, want); end
    end
    for (int i = 0; i < 4; i++) begin
      exp = tx_exp.size() ? tx_exp.pop_front() : 8'h00;
      got = tx_obs.size() ? tx_obs.pop_front() : 8'hFF;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL fair_tx[%0d] got=%h exp=%h", i, got, exp); end
    end
    rxf_n = 1'b1;
    txe_n = 1'b1;
    tick(5);
    for (int i = 0; i < RXD; i++) begin
      exp = rx_exp.size() ? rx_exp.pop_front() : 8'h00;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp) begin
        failures++; $display("FAIL fair_rx[%0d] got=%h/v%b exp=%h", i, rx_data, rx_valid, exp);
      end
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end
    tick(30);
    clear_logs();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp, got;
    int n;
    push_tx(8'h99);
    rxf_n = 1'b0;
    n = 0;
    while (rd_n !== 1'b0 && n < 30) begin tick(1); n++; end
    tick(1);
    checks++;
    if (rd_n !== 1'b0 || tx_level !== 5'd1) begin
      failures++; $display("FAIL mid_setup got=%b/%0d exp=0/1", rd_n, tx_level);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_n, wr_n, siwu_n, oe} !== 4'b1110) begin
      failures++; $display("FAIL mid_reset_pins got=%b exp=1110", {rd_n, wr_n, siwu_n, oe});
    end
    checks++;
    if (tx_level !== 5'd0 || rx_level !== 3'd0) begin
      failures++; $display("FAIL mid_reset_levels got=%0d/%0d exp=0/0", tx_level, rx_level);
    end
    rxf_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_logs();
    rxf_n = 1'b0;
    n = 0;
    while (rd_n !== 1'b0 && n < 30) begin tick(1); n++; end
    rxf_n = 1'b1;
    tick(14);
    exp = rx_exp.size() ? rx_exp.pop_front() : 8'h00;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      failures++; $display("FAIL resume_rx got=%h/v%b exp=%h", rx_data, rx_valid, exp);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    txe_n = 1'b0;
    tick(3);
    push_tx(8'hC3);
    tick(30);
    exp = tx_exp.size() ? tx_exp.pop_front() : 8'h00;
    got = tx_obs.size() ? tx_obs.pop_front() : 8'hFF;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL resume_tx got=%h exp=%h", got, exp); end
    tick(30);
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_siwu();
    test_single_rx();
    test_rx_full();
    test_fairness();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
